core_hazard_sb: RTL and testbench
=================================

Name: core_hazard_sb

Overview:
- Parametrised next-generation hazard unit for the in-order core.
- Generalises decode-stage stall/forward resolution from the fixed X/M/W stages to NFWD ordered forwarding sources.
- Adds a per-register scoreboard for long-latency ops (mul/div, uncached loads) that write back out of band, bounded by an outstanding-op counter.
- Sits beside decode: stall/forward outputs are combinational; scoreboard, counters and perf stall counter are registered.

Parameters:
- XLEN, 32, data width of forwarded values.
- NREGS, 32, architectural register count; register 0 is hard zero.
- RW, 5, register index width (log2 NREGS).
- NFWD, 3, forwarding sources; index 0 = youngest (X), highest priority.
- MAX_LOP, 2, maximum outstanding long-latency ops (>=1).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- d_valid  in  1  decode slot holds an instruction
- d_flush  in  1  decode slot being flushed this cycle
- d_rs1, d_rs2  in  RW each  decode source registers
- d_rs1_used, d_rs2_used  in  1 each  source actually read
- d_rd  in  RW  decode destination
- d_lop  in  1  decode instruction is a long-latency op
- src_valid  in  NFWD  per-source valid
- src_wen  in  NFWD  per-source register write enable
- src_ready  in  NFWD  per-source result available (0 for load in M)
- src_rd  in  NFWD*RW  per-source destination, packed, source i at [i*RW +: RW]
- src_wdata  in  NFWD*XLEN  per-source result, packed likewise
- lwb_valid  in  1  long-op writeback strobe
- lwb_rd  in  RW  long-op writeback register
- lwb_wdata  in  XLEN  long-op writeback data
- sb_clear  in  1  kill all outstanding long ops (exception/redirect)
- stall  out  1  hold decode
- lop_issue  out  1  long op leaves decode this cycle
- fwd_rs1en, fwd_rs2en  out  1 each  forward override valid
- fwd_value1, fwd_value2  out  XLEN each  forwarded operand
- sb_busy  out  NREGS  registered scoreboard bits
- lop_cnt  out  clog2(MAX_LOP+1)  outstanding long ops
- stall_cnt  out  32  saturating count of stalled cycles

Behaviour:
- Reset (rst=1 at posedge): sb_busy=0, lop_cnt=0, stall_cnt=0. Combinational outputs follow inputs with those state values.
- Match per source i and operand rsN: src_valid[i] & src_wen[i] & src_rd[i]!=0 & src_rd[i]==rsN & rsN_used.
- Forward select: lowest matching i wins. If no source matches and lwb_valid & lwb_rd==rsN & rsN!=0, forward lwb_wdata. fwd_rsNen=1 when any forward is selected; fwd_valueN=0 when fwd_rsNen=0.
- Stall causes, any of:
  - (a) the selected source has src_ready=0;
  - (b) sb_busy[rsN] & rsN_used & not bypassed by lwb this cycle;
  - (c) d_lop & lop_cnt==MAX_LOP & no lwb_valid this cycle;
  - (d) d_rd!=0 & sb_busy[d_rd] (WAW) & not cleared by lwb this cycle.
- stall is gated by d_valid & ~d_flush.
- lop_issue = d_valid & ~d_flush & ~stall & d_lop & ~sb_clear.
- Scoreboard update at posedge, in priority order:
  - sb_clear: all bits 0, lop_cnt=0.
  - Otherwise lwb_valid clears sb_busy[lwb_rd], and lop_issue with d_rd!=0 sets sb_busy[d_rd]. Set wins on the same index.
  - lop_cnt += lop_issue - lwb_valid, net 0 when both occur.
  - lwb_valid with lop_cnt==0 is ignored, no underflow. Bit 0 is never set.
- lop_issue with d_rd==0 still counts in lop_cnt.
- stall_cnt increments when stall=1 and saturates at 0xFFFFFFFF.
- Reset mid-operation discards all outstanding state. A later lwb_valid then has no effect on the count.

Test Plan:
- Source 0 (X) valid/wen/ready, rd=5, wdata=0x11; source 1, rd=5, wdata=0x22; d_rs1=5 used -> fwd_rs1en=1, fwd_value1=0x11, stall=0.
- Source 1 rd=7 with src_ready=0; d_rs2=7 used -> stall=1, stall_cnt +1 per cycle. Same with d_rs2_used=0 -> stall=0.
- Issue long op (d_lop, d_rd=9): sb_busy[9]=1, lop_cnt=1. Next instruction rs1=9 -> stall until lwb_valid rd=9, wdata=0xABCD. That cycle: stall=0, fwd_value1=0xABCD. Next cycle: sb_busy[9]=0, lop_cnt=0.
- MAX_LOP=2: issue rd=3 and rd=4, then third d_lop -> stall. Same cycle as lwb rd=3 -> issues, lop_cnt stays 2.
- lwb rd=6 same cycle as lop_issue d_rd=6 -> sb_busy[6]=1, lop_cnt unchanged. Then sb_clear -> sb_busy=0, lop_cnt=0.
- rst asserted with lop_cnt=2 -> all state 0. Later lwb_valid -> lop_cnt stays 0. Register 0 is never forwarded or stalled on.

Source files
------------

// File: rtl/core_hazard_sb_if.sv
// Decode-side hazard bundle: decode operands, forwarding sources,
// long-op writeback, and the stall/forward/scoreboard results.
interface core_hazard_sb_if #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int RW      = 5,
    parameter int NFWD    = 3,
    parameter int MAX_LOP = 2
);
    localparam int CW = $clog2(MAX_LOP + 1);

    logic                 d_valid;
    logic                 d_flush;
    logic [RW-1:0]        d_rs1;
    logic [RW-1:0]        d_rs2;
    logic                 d_rs1_used;
    logic                 d_rs2_used;
    logic [RW-1:0]        d_rd;
    logic                 d_lop;
    logic [NFWD-1:0]      src_valid;
    logic [NFWD-1:0]      src_wen;
    logic [NFWD-1:0]      src_ready;
    logic [NFWD*RW-1:0]   src_rd;
    logic [NFWD*XLEN-1:0] src_wdata;
    logic                 lwb_valid;
    logic [RW-1:0]        lwb_rd;
    logic [XLEN-1:0]      lwb_wdata;
    logic                 sb_clear;

    logic                 stall;
    logic                 lop_issue;
    logic                 fwd_rs1en;
    logic                 fwd_rs2en;
    logic [XLEN-1:0]      fwd_value1;
    logic [XLEN-1:0]      fwd_value2;
    logic [NREGS-1:0]     sb_busy;
    logic [CW-1:0]        lop_cnt;
    logic [31:0]          stall_cnt;

    modport master (
        output d_valid, d_flush, d_rs1, d_rs2, d_rs1_used, d_rs2_used,
        output d_rd, d_lop, src_valid, src_wen, src_ready, src_rd,
        output src_wdata, lwb_valid, lwb_rd, lwb_wdata, sb_clear,
        input  stall, lop_issue, fwd_rs1en, fwd_rs2en, fwd_value1,
        input  fwd_value2, sb_busy, lop_cnt, stall_cnt
    );

    modport slave (
        input  d_valid, d_flush, d_rs1, d_rs2, d_rs1_used, d_rs2_used,
        input  d_rd, d_lop, src_valid, src_wen, src_ready, src_rd,
        input  src_wdata, lwb_valid, lwb_rd, lwb_wdata, sb_clear,
        output stall, lop_issue, fwd_rs1en, fwd_rs2en, fwd_value1,
        output fwd_value2, sb_busy, lop_cnt, stall_cnt
    );
endinterface

// File: rtl/core_hazard_sb.sv
// Decode hazard unit: N-source forwarding, stall resolution and a
// per-register scoreboard for out-of-band long-latency writebacks.
module core_hazard_sb #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int RW      = 5,
    parameter int NFWD    = 3,
    parameter int MAX_LOP = 2
) (
    input logic              clk,
    input logic              rst,
    core_hazard_sb_if.slave  hz
);
    localparam int CW = $clog2(MAX_LOP + 1);

    logic [NREGS-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [31:0]      scnt_q, scnt_d;

    logic             en1, en2, rdy1, rdy2;
    logic [XLEN-1:0]  v1, v2;
    logic             lwb1, lwb2, lwb_waw;
    logic             hz1, hz2, lop_full, waw;
    logic             stall, issue;

    // Walk oldest to youngest so the youngest match overwrites.
    always_comb begin
        logic [RW-1:0] rdi;
        en1  = 1'b0;
        en2  = 1'b0;
        rdy1 = 1'b1;
        rdy2 = 1'b1;
        v1   = '0;
        v2   = '0;
        rdi  = '0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            rdi = hz.src_rd[i*RW +: RW];
            if (hz.src_valid[i] && hz.src_wen[i] && rdi != '0) begin
                if (hz.d_rs1_used && rdi == hz.d_rs1) begin
                    en1  = 1'b1;
                    rdy1 = hz.src_ready[i];
                    v1   = hz.src_wdata[i*XLEN +: XLEN];
                end
                if (hz.d_rs2_used && rdi == hz.d_rs2) begin
                    en2  = 1'b1;
                    rdy2 = hz.src_ready[i];
                    v2   = hz.src_wdata[i*XLEN +: XLEN];
                end
            end
        end
        lwb1 = hz.lwb_valid && hz.lwb_rd == hz.d_rs1;
        lwb2 = hz.lwb_valid && hz.lwb_rd == hz.d_rs2;
        if (!en1 && lwb1 && hz.d_rs1 != '0) begin
            en1 = 1'b1;
            v1  = hz.lwb_wdata;
        end
        if (!en2 && lwb2 && hz.d_rs2 != '0) begin
            en2 = 1'b1;
            v2  = hz.lwb_wdata;
        end
    end

    assign hz1 = (en1 && !rdy1) ||
                 (sb_q[hz.d_rs1] && hz.d_rs1_used && !lwb1);
    assign hz2 = (en2 && !rdy2) ||
                 (sb_q[hz.d_rs2] && hz.d_rs2_used && !lwb2);

    assign lop_full = hz.d_lop && cnt_q == CW'(MAX_LOP) && !hz.lwb_valid;
    assign lwb_waw  = hz.lwb_valid && hz.lwb_rd == hz.d_rd;
    assign waw      = hz.d_rd != '0 && sb_q[hz.d_rd] && !lwb_waw;

    assign stall = hz.d_valid && !hz.d_flush &&
                   (hz1 || hz2 || lop_full || waw);
    assign issue = hz.d_valid && !hz.d_flush && !stall &&
                   hz.d_lop && !hz.sb_clear;

    // Writeback with nothing outstanding clears its bit but never
    // underflows the counter.
    always_comb begin
        logic dec;
        sb_d   = sb_q;
        cnt_d  = cnt_q;
        scnt_d = scnt_q;
        dec    = hz.lwb_valid && cnt_q != '0;
        if (hz.sb_clear) begin
            sb_d  = '0;
            cnt_d = '0;
        end else begin
            if (hz.lwb_valid) sb_d[hz.lwb_rd] = 1'b0;
            if (issue && hz.d_rd != '0) sb_d[hz.d_rd] = 1'b1;
            if (issue && !dec) cnt_d = cnt_q + CW'(1);
            else if (!issue && dec) cnt_d = cnt_q - CW'(1);
        end
        if (stall && scnt_q != '1) scnt_d = scnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q   <= '0;
            cnt_q  <= '0;
            scnt_q <= '0;
        end else begin
            sb_q   <= sb_d;
            cnt_q  <= cnt_d;
            scnt_q <= scnt_d;
        end
    end

    assign hz.stall      = stall;
    assign hz.lop_issue  = issue;
    assign hz.fwd_rs1en  = en1;
    assign hz.fwd_rs2en  = en2;
    assign hz.fwd_value1 = v1;
    assign hz.fwd_value2 = v2;
    assign hz.sb_busy    = sb_q;
    assign hz.lop_cnt    = cnt_q;
    assign hz.stall_cnt  = scnt_q;
endmodule

// File: tb/tb_core_hazard_sb.sv
// Bench for core_hazard_sb: rule-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_core_hazard_sb;
    localparam int XLEN = 32, NREGS = 32, RW = 5, NFWD = 3, MAX_LOP = 2;

    logic clk, rst;
    int   checks = 0;
    int   errors = 0;

    core_hazard_sb_if #(XLEN, NREGS, RW, NFWD, MAX_LOP) bus();

    core_hazard_sb #(
        .XLEN(XLEN), .NREGS(NREGS), .RW(RW), .NFWD(NFWD), .MAX_LOP(MAX_LOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model state: busy flags, outstanding count, stall tally.
    bit     mbusy[NREGS];
    int     mcnt   = 0;
    longint mstall = 0;
    bit     model_ok = 0;

    function automatic void operand(input logic [RW-1:0] rs, input logic used,
                                    output logic en, output logic [XLEN-1:0] val,
                                    output logic haz);
        en = 0; val = '0; haz = 0;
        if (used && rs != 0) begin
            for (int i = 0; i < NFWD; i++) begin
                if (bus.src_valid[i] && bus.src_wen[i] &&
                    bus.src_rd[i*RW +: RW] == rs) begin
                    en  = 1;
                    val = bus.src_wdata[i*XLEN +: XLEN];
                    haz = !bus.src_ready[i];
                    break;
                end
            end
        end
        if (!en && bus.lwb_valid && bus.lwb_rd == rs && rs != 0) begin
            en  = 1;
            val = bus.lwb_wdata;
        end
        if (used && mbusy[rs] && !(bus.lwb_valid && bus.lwb_rd == rs)) haz = 1;
    endfunction

    function automatic void eval(output logic st, output logic iss,
                                 output logic e1, output logic [XLEN-1:0] x1,
                                 output logic e2, output logic [XLEN-1:0] x2);
        logic h1, h2, cause;
        operand(bus.d_rs1, bus.d_rs1_used, e1, x1, h1);
        operand(bus.d_rs2, bus.d_rs2_used, e2, x2, h2);
        cause = h1 || h2 ||
                (bus.d_lop && mcnt == MAX_LOP && !bus.lwb_valid) ||
                (bus.d_rd != 0 && mbusy[bus.d_rd] &&
                 !(bus.lwb_valid && bus.lwb_rd == bus.d_rd));
        st  = bus.d_valid && !bus.d_flush && cause;
        iss = bus.d_valid && !bus.d_flush && !st && bus.d_lop && !bus.sb_clear;
    endfunction

    always @(posedge clk) begin
        logic st, iss, e1, e2;
        logic [XLEN-1:0] x1, x2;
        if (rst) begin
            foreach (mbusy[r]) mbusy[r] = 0;
            mcnt = 0; mstall = 0; model_ok = 1;
        end else if (model_ok) begin
            eval(st, iss, e1, x1, e2, x2);
            if (bus.sb_clear) begin
                foreach (mbusy[r]) mbusy[r] = 0;
                mcnt = 0;
            end else begin
                if (bus.lwb_valid) mbusy[bus.lwb_rd] = 0;
                if (iss && bus.d_rd != 0) mbusy[bus.d_rd] = 1;
                mcnt = mcnt + (iss ? 1 : 0) - ((bus.lwb_valid && mcnt > 0) ? 1 : 0);
            end
            if (st && mstall < 64'hFFFF_FFFF) mstall++;
        end
    end

    always @(negedge clk) begin
        logic st, iss, e1, e2;
        logic [XLEN-1:0] x1, x2;
        logic [NREGS-1:0] vec;
        if (model_ok) begin
            eval(st, iss, e1, x1, e2, x2);
            for (int r = 0; r < NREGS; r++) vec[r] = mbusy[r];
            chk("m_stall", bus.stall, st);
            chk("m_issue", bus.lop_issue, iss);
            chk("m_en1", bus.fwd_rs1en, e1);
            chk("m_val1", bus.fwd_value1, x1);
            chk("m_en2", bus.fwd_rs2en, e2);
            chk("m_val2", bus.fwd_value2, x2);
            chk("m_busy", bus.sb_busy, vec);
            chk("m_lopcnt", bus.lop_cnt, mcnt);
            chk("m_stallcnt", bus.stall_cnt, mstall);
        end
    end

    task automatic idle();
        bus.d_valid = 0; bus.d_flush = 0; bus.d_rs1 = 0; bus.d_rs2 = 0;
        bus.d_rs1_used = 0; bus.d_rs2_used = 0; bus.d_rd = 0; bus.d_lop = 0;
        bus.src_valid = 0; bus.src_wen = 0; bus.src_ready = 0;
        bus.src_rd = 0; bus.src_wdata = 0;
        bus.lwb_valid = 0; bus.lwb_rd = 0; bus.lwb_wdata = 0; bus.sb_clear = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic src(input int i, input logic rdy, input logic [RW-1:0] rd,
                       input logic [XLEN-1:0] wd);
        bus.src_valid[i] = 1; bus.src_wen[i] = 1; bus.src_ready[i] = rdy;
        bus.src_rd[i*RW +: RW] = rd;
        bus.src_wdata[i*XLEN +: XLEN] = wd;
    endtask

    task automatic lop(input logic [RW-1:0] rd);
        bus.d_valid = 1; bus.d_lop = 1; bus.d_rd = rd;
    endtask

    initial begin
        rst = 1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_busy", bus.sb_busy, 0);
        chk("rst_lopcnt", bus.lop_cnt, 0);
        chk("rst_stallcnt", bus.stall_cnt, 0);
        step(); rst = 0;

        // youngest source wins
        src(0, 1, 5, 32'h11); src(1, 1, 5, 32'h22);
        bus.d_valid = 1; bus.d_rs1 = 5; bus.d_rs1_used = 1;
        @(negedge clk);
        chk("fwd_x_en", bus.fwd_rs1en, 1);
        chk("fwd_x_val", bus.fwd_value1, 32'h11);
        chk("fwd_x_stall", bus.stall, 0);

        // load-use stall on a not-ready source
        step(); idle();
        src(1, 0, 7, 32'h99);
        bus.d_valid = 1; bus.d_rs2 = 7; bus.d_rs2_used = 1;
        @(negedge clk);
        chk("lu_stall", bus.stall, 1);
        repeat (3) @(posedge clk);
        #1 bus.d_rs2_used = 0;
        @(negedge clk);
        chk("lu_unused_stall", bus.stall, 0);
        chk("lu_unused_en", bus.fwd_rs2en, 0);
        chk("lu_stallcnt", bus.stall_cnt, 3);

        // long op then dependent consumer
        step(); idle(); lop(9);
        @(negedge clk);
        chk("lop_issue9", bus.lop_issue, 1);
        step(); idle();
        bus.d_valid = 1; bus.d_rs1 = 9; bus.d_rs1_used = 1;
        @(negedge clk);
        chk("sb9_set", bus.sb_busy[9], 1);
        chk("lop_cnt1", bus.lop_cnt, 1);
        chk("sb9_stall", bus.stall, 1);
        step(); step();
        bus.lwb_valid = 1; bus.lwb_rd = 9; bus.lwb_wdata = 32'hABCD;
        @(negedge clk);
        chk("lwb_stall", bus.stall, 0);
        chk("lwb_en", bus.fwd_rs1en, 1);
        chk("lwb_val", bus.fwd_value1, 32'hABCD);
        step(); idle();
        @(negedge clk);
        chk("sb9_clr", bus.sb_busy, 0);
        chk("lop_cnt0", bus.lop_cnt, 0);

        // outstanding limit
        step(); lop(3);
        step(); lop(4);
        step(); lop(8);
        @(negedge clk);
        chk("full_stall", bus.stall, 1);
        chk("full_cnt", bus.lop_cnt, 2);
        step(); bus.lwb_valid = 1; bus.lwb_rd = 3;
        @(negedge clk);
        chk("full_lwb_stall", bus.stall, 0);
        chk("full_lwb_issue", bus.lop_issue, 1);
        step(); idle();
        @(negedge clk);
        chk("full_cnt2", bus.lop_cnt, 2);
        chk("full_busy", bus.sb_busy, 32'h0000_0110);

        // set wins over same-index clear, then kill
        step(); lop(6); bus.lwb_valid = 1; bus.lwb_rd = 6;
        @(negedge clk);
        chk("same6_issue", bus.lop_issue, 1);
        step(); idle();
        @(negedge clk);
        chk("same6_busy", bus.sb_busy, 32'h0000_0150);
        chk("same6_cnt", bus.lop_cnt, 2);
        step(); bus.sb_clear = 1;
        step(); idle();
        @(negedge clk);
        chk("clr_busy", bus.sb_busy, 0);
        chk("clr_cnt", bus.lop_cnt, 0);

        // WAW, flush gating, priority over a not-ready older source
        step(); lop(12);
        step(); idle(); bus.d_valid = 1; bus.d_rd = 12;
        @(negedge clk);
        chk("waw_stall", bus.stall, 1);
        #1 bus.d_flush = 1;
        #1 chk("flush_stall", bus.stall, 0);
        step(); bus.d_flush = 0; bus.lwb_valid = 1; bus.lwb_rd = 12;
        @(negedge clk);
        chk("waw_lwb_stall", bus.stall, 0);
        step(); idle();
        src(1, 1, 13, 32'h33); src(2, 0, 13, 32'h44);
        bus.d_valid = 1; bus.d_rs1 = 13; bus.d_rs1_used = 1;
        @(negedge clk);
        chk("prio_val", bus.fwd_value1, 32'h33);
        chk("prio_stall", bus.stall, 0);

        // reset discards outstanding ops
        step(); idle(); lop(10);
        step(); lop(11);
        step(); idle();
        @(negedge clk);
        chk("pre_rst_cnt", bus.lop_cnt, 2);
        step(); rst = 1;
        step(); rst = 0;
        @(negedge clk);
        chk("mid_rst_cnt", bus.lop_cnt, 0);
        chk("mid_rst_busy", bus.sb_busy, 0);
        chk("mid_rst_stallcnt", bus.stall_cnt, 0);
        step(); bus.lwb_valid = 1; bus.lwb_rd = 10;
        step(); idle();
        @(negedge clk);
        chk("post_rst_lwb_cnt", bus.lop_cnt, 0);

        // register 0 is never forwarded or stalled on
        step();
        src(0, 1, 0, 32'h55); src(1, 0, 0, 32'h66);
        bus.d_valid = 1; bus.d_rs1_used = 1; bus.d_rs2_used = 1;
        bus.lwb_valid = 1; bus.lwb_rd = 0; bus.lwb_wdata = 32'h77;
        @(negedge clk);
        chk("r0_en1", bus.fwd_rs1en, 0);
        chk("r0_val1", bus.fwd_value1, 0);
        chk("r0_en2", bus.fwd_rs2en, 0);
        chk("r0_stall", bus.stall, 0);
        step(); idle(); lop(0);
        @(negedge clk);
        chk("r0_issue", bus.lop_issue, 1);
        step(); idle();
        @(negedge clk);
        chk("r0_cnt", bus.lop_cnt, 1);
        chk("r0_busy", bus.sb_busy, 0);

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
